// File: rtl/reg_file.sv
// 32 x 32-bit RISC-V integer register file: two combinational read ports, one clocked write port, x0 hardwired to zero.
// Optional build macro REG_FILE_BYPASS_EN adds write-first forwarding from WD3 to the read ports.
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  WE3,
   input  logic [ADDR_WIDTH-1:0] A1,
   input  logic [ADDR_WIDTH-1:0] A2,
   input  logic [ADDR_WIDTH-1:0] A3,
   input  logic [DATA_WIDTH-1:0] WD3,
   output logic [DATA_WIDTH-1:0] RD1,
   output logic [DATA_WIDTH-1:0] RD2
);

   localparam int NREGS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NREGS];
   logic [DATA_WIDTH-1:0] regs_d [NREGS];
   logic                  wr_hit;
   logic [DATA_WIDTH-1:0] rd1;
   logic [DATA_WIDTH-1:0] rd2;

   // A write to x0 is dropped here so entry 0 never leaves its reset value.
   assign wr_hit = WE3 && (A3 != '0);

   always_comb begin
      regs_d = regs_q;
      if (wr_hit) begin
         regs_d[A3] = WD3;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd1 = regs_q[A1];
      rd2 = regs_q[A2];
`ifdef REG_FILE_BYPASS_EN
      if (wr_hit && (A1 == A3)) begin
         rd1 = WD3;
      end
      if (wr_hit && (A2 == A3)) begin
         rd2 = WD3;
      end
`endif
      // Reset masks the outputs directly so the forwarding path cannot leak WD3.
      if (reset || (A1 == '0)) begin
         rd1 = '0;
      end
      if (reset || (A2 == '0)) begin
         rd2 = '0;
      end
   end

   assign RD1 = rd1;
   assign RD2 = rd2;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand-written reset and read-during-write sequences, random traffic against an array model.
module tb_reg_file;

   logic        clk;
   logic        reset;
   logic        WE3;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [4:0]  A3;
   logic [31:0] WD3;
   logic [31:0] RD1;
   logic [31:0] RD2;

   int checks;
   int errors;
   logic [31:0] model [32];

   reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk  (clk),
      .reset(reset),
      .WE3  (WE3),
      .A1   (A1),
      .A2   (A2),
      .A3   (A3),
      .WD3  (WD3),
      .RD1  (RD1),
      .RD2  (RD2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        we;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                              input logic [4:0] a3, input logic [31:0] wd,
                                              input logic pre_edge);
      if (a == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
      if (pre_edge && we && (a3 != 5'd0) && (a3 == a)) return wd;
`endif
      return model[a];
   endfunction

   // Drive one set of inputs at the falling edge, then let a rising edge commit them.
   task automatic drive(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input logic [31:0] wd);
      @(negedge clk);
      WE3 = we;
      A1  = a1;
      A2  = a2;
      A3  = a3;
      WD3 = wd;
   endtask

   task automatic commit();
      @(posedge clk);
      if (WE3 && (A3 != 5'd0)) model[A3] = WD3;
      #1;
   endtask

   vec_t vecs [8];
   logic [31:0] e1;
   logic [31:0] e2;

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      reset = 1'b1;
      WE3 = 1'b0;
      A1 = 5'd0;
      A2 = 5'd0;
      A3 = 5'd0;
      WD3 = 32'h0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 5'd5, 5'd31, 5'd0, 32'h0);
      #1;
      chk("reset_rd1_x5", RD1, 32'h0);
      chk("reset_rd2_x31", RD2, 32'h0);

      // Directed table: expected values after the committing edge
      vecs[0] = '{1'b1, 5'd2,  5'd3,  5'd2,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vecs[1] = '{1'b1, 5'd3,  5'd2,  5'd3,  32'h0000_0003, 32'h0000_0003, 32'h0000_0000};
      vecs[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  32'h0000_0003, 32'h0000_0000, 32'h0000_0000};
      vecs[3] = '{1'b0, 5'd3,  5'd1,  5'd3,  32'h0000_0001, 32'h0000_0003, 32'h0000_0000};
      vecs[4] = '{1'b0, 5'd2,  5'd3,  5'd1,  32'h0000_0002, 32'h0000_0000, 32'h0000_0003};
      vecs[5] = '{1'b1, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[6] = '{1'b1, 5'd1,  5'd31, 5'd1,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hFFFF_FFFF};
      vecs[7] = '{1'b0, 5'd4,  5'd1,  5'd1,  32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5};
      for (int v = 0; v < 8; v++) begin
         drive(vecs[v].we, vecs[v].a1, vecs[v].a2, vecs[v].a3, vecs[v].wd);
         commit();
         chk($sformatf("vec%0d_rd1", v), RD1, vecs[v].exp1);
         chk($sformatf("vec%0d_rd2", v), RD2, vecs[v].exp2);
      end

      // Asynchronous reset mid-run
      drive(1'b1, 5'd5, 5'd5, 5'd5, 32'hDEAD_BEEF);
      commit();
      drive(1'b0, 5'd5, 5'd1, 5'd0, 32'h0);
      #1;
      chk("pre_reset_x5", RD1, 32'hDEAD_BEEF);
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset_x5", RD1, 32'h0);
      chk("async_reset_x1", RD2, 32'h0);
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      @(negedge clk);
      WE3 = 1'b1;
      A3  = 5'd6;
      WD3 = 32'h1234_5678;
      A1  = 5'd6;
      A2  = 5'd6;
      #1;
      chk("reset_hold_bypass_rd1", RD1, 32'h0);
      @(posedge clk);
      #1;
      chk("reset_hold_write_rd2", RD2, 32'h0);
      @(negedge clk);
      WE3 = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         A1 = i[4:0];
         A2 = 5'(31 - i);
         #1;
         chk($sformatf("post_reset_rd1_%0d", i), RD1, 32'h0);
         chk($sformatf("post_reset_rd2_%0d", i), RD2, 32'h0);
      end

      // Full sweep
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'd0, 5'd0, i[4:0], 32'h1000_0000 + i);
         commit();
      end
      @(negedge clk);
      WE3 = 1'b0;
      for (int i = 0; i < 32; i++) begin
         A1 = i[4:0];
         A2 = 5'(31 - i);
         #1;
         e1 = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
         e2 = (i == 31) ? 32'h0 : 32'h1000_0000 + (31 - i);
         chk($sformatf("sweep_rd1_%0d", i), RD1, e1);
         chk($sformatf("sweep_rd2_%0d", i), RD2, e2);
      end

      // Read during write on the same address
      drive(1'b1, 5'd0, 5'd0, 5'd7, 32'h0000_0011);
      commit();
      drive(1'b1, 5'd7, 5'd0, 5'd7, 32'h0000_0022);
      #1;
`ifdef REG_FILE_BYPASS_EN
      chk("rdw_before_edge", RD1, 32'h0000_0022);
`else
      chk("rdw_before_edge", RD1, 32'h0000_0011);
`endif
      chk("rdw_x0_port2", RD2, 32'h0);
      commit();
      chk("rdw_after_edge", RD1, 32'h0000_0022);
      drive(1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
      #1;
      chk("x0_write_pre_rd1", RD1, 32'h0);
      commit();
      chk("x0_write_post_rd2", RD2, 32'h0);

      // Random traffic against the array model
      for (int n = 0; n < 400; n++) begin
         logic        we;
         logic [4:0]  a1;
         logic [4:0]  a2;
         logic [4:0]  a3;
         logic [31:0] wd;
         we = 1'($urandom_range(0, 1));
         a3 = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
         wd = $urandom;
         drive(we, a1, a2, a3, wd);
         #1;
         chk($sformatf("rand%0d_pre_rd1", n), RD1, model_read(a1, we, a3, wd, 1'b1));
         chk($sformatf("rand%0d_pre_rd2", n), RD2, model_read(a2, we, a3, wd, 1'b1));
         commit();
         chk($sformatf("rand%0d_post_rd1", n), RD1, model_read(a1, we, a3, wd, 1'b0));
         chk($sformatf("rand%0d_post_rd2", n), RD2, model_read(a2, we, a3, wd, 1'b0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
